cla_4_bit: RTL and testbench

CLA_4_BIT -- requirements
Module: cla_4_bit

---
 rtl/cla_4_bit.sv | 108 ++++++++++
 tb/tb_cla_4_bit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cla_4_bit.sv
// -----------------------------------------------------------------------------
// cla_4_bit
// Registered 4-bit carry-lookahead adder. Per-bit propagate/generate terms feed
// flat two-level carry equations, so no carry ripples bit to bit. One operation
// is accepted every cycle when in_valid is high. The result appears one cycle
// later. When in_valid is low, the result registers hold their value and
// out_valid drops.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous, active-high reset
//   a, b      in   4  unsigned addends
//   cin       in   1  carry-in
//   in_valid  in   1  a/b/cin carry a valid operation this cycle
//   sum       out  4  registered sum bits [3:0]
//   cout      out  1  registered carry-out
//   group_p   out  1  registered group propagate P3&P2&P1&P0
//   group_g   out  1  registered group generate
//   out_valid out  1  registered outputs hold a fresh result
// -----------------------------------------------------------------------------
module cla_4_bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       in_valid,
    output logic [3:0] sum,
    output logic       cout,
    output logic       group_p,
    output logic       group_g,
    output logic       out_valid
);

    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [4:0] c_s;
    logic [3:0] sum_s;
    logic       gp_s;
    logic       gg_s;

    logic [3:0] sum_d,       sum_q;
    logic       cout_d,      cout_q;
    logic       group_p_d,   group_p_q;
    logic       group_g_d,   group_g_q;
    logic       out_valid_d, out_valid_q;

    // Propagate/generate terms and flat lookahead carries.
    always_comb begin
        p_s    = a ^ b;
        g_s    = a & b;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
        sum_s  = p_s ^ c_s[3:0];
        gp_s   = &p_s;
        // Group generate is c4 with the carry-in term removed.
        gg_s   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    end

    // Next-state: load a new result on in_valid, otherwise hold and drop valid.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        group_p_d   = group_p_q;
        group_g_d   = group_g_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = sum_s;
            cout_d      = c_s[4];
            group_p_d   = gp_s;
            group_g_d   = gg_s;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Result registers with synchronous reset taking priority over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= 4'b0000;
            cout_q      <= 1'b0;
            group_p_q   <= 1'b0;
            group_g_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            group_p_q   <= group_p_d;
            group_g_q   <= group_g_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign group_p   = group_p_q;
    assign group_g   = group_g_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_4_bit.sv
// -----------------------------------------------------------------------------
// tb_cla_4_bit
// Self-checking bench for cla_4_bit. An arithmetic reference model (a+b+cin)
// tracks the expected registered outputs. A negedge process compares every
// output on every cycle. Directed cases pin the model with literal results.
// The bench then runs an exhaustive 512-vector sweep and a randomized phase
// with random in_valid and occasional reset.
// -----------------------------------------------------------------------------
module tb_cla_4_bit;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] sum;
    logic       cout;
    logic       group_p;
    logic       group_g;
    logic       out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [3:0] m_sum    = 4'h0;
    logic       m_cout   = 1'b0;
    logic       m_gp     = 1'b0;
    logic       m_gg     = 1'b0;
    logic       m_ov     = 1'b0;
    logic       m_cin_op = 1'b0;

    cla_4_bit dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .group_p   (group_p),
        .group_g   (group_g),
        .out_valid (out_valid)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: plain integer addition of the sampled operation.
    always @(posedge clk) begin
        int total;
        total = int'(a) + int'(b) + int'(cin);
        if (rst) begin
            m_sum <= 4'h0; m_cout <= 1'b0; m_gp <= 1'b0; m_gg <= 1'b0; m_ov <= 1'b0;
        end else if (in_valid) begin
            m_sum    <= 4'(total % 16);
            m_cout   <= (total >= 16);
            m_gp     <= ((a ^ b) == 4'hF);
            m_gg     <= ((int'(a) + int'(b)) >= 16);
            m_ov     <= 1'b1;
            m_cin_op <= cin;
        end else begin
            m_ov <= 1'b0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        n_tests++;
        if ({sum, cout, group_p, group_g, out_valid} !== {m_sum, m_cout, m_gp, m_gg, m_ov}) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t: got sum=%h cout=%b gp=%b gg=%b ov=%b, expected sum=%h cout=%b gp=%b gg=%b ov=%b",
                     $time, sum, cout, group_p, group_g, out_valid, m_sum, m_cout, m_gp, m_gg, m_ov);
        end
        if (out_valid === 1'b1) begin
            n_tests++;
            if (cout !== (group_g | (group_p & m_cin_op))) begin
                n_fail++;
                $display("FAIL cout_vs_group t=%0t: cout=%b, expected %b", $time, cout,
                         group_g | (group_p & m_cin_op));
            end
        end
    end

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                         input logic tv, input logic tr);
        @(negedge clk);
        a = ta; b = tb; cin = tc; in_valid = tv; rst = tr;
    endtask

    // Drive, then sample just after the capturing edge.
    task automatic drive_wait(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                              input logic tv, input logic tr);
        drive(ta, tb, tc, tv, tr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1; in_valid = 1'b1;

        // Reset for two cycles with an active operation present
        @(posedge clk);
        drive_wait(4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
        chk("reset_outputs", {sum, cout, group_p, group_g, out_valid}, 8'b0000_0000);

        // Single operations
        drive_wait(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        chk("add_0_0", {3'b000, cout, sum}, 8'h00);
        chk("add_0_0_valid", {7'd0, out_valid}, 8'h01);
        drive_wait(4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0);
        chk("add_3_1", {3'b000, cout, sum}, 8'h04);
        drive_wait(4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0);
        chk("add_a_5", {1'b0, group_p, group_g, cout, sum}, 8'b0100_1111);

        // Carry and wrap-around
        drive_wait(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
        chk("add_f_f_1", {2'b00, group_g, cout, sum}, 8'b0011_1111);
        drive_wait(4'b1100, 4'b1010, 1'b1, 1'b1, 1'b0);
        chk("add_c_a_1", {3'b000, cout, sum}, 8'b0001_0111);
        drive_wait(4'b0001, 4'b1111, 1'b0, 1'b1, 1'b0);
        chk("add_1_f", {1'b0, group_p, group_g, cout, sum}, 8'b0011_0000);
        drive_wait(4'b0101, 4'b0101, 1'b1, 1'b1, 1'b0);
        chk("add_5_5_1", {3'b000, cout, sum}, 8'b0000_1011);

        // Back-to-back then idle
        drive_wait(4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0);
        chk("b2b_first", {2'b00, out_valid, cout, sum}, 8'b0010_0100);
        drive_wait(4'b0001, 4'b1111, 1'b0, 1'b1, 1'b0);
        chk("b2b_second", {2'b00, out_valid, cout, sum}, 8'b0011_0000);
        drive_wait(4'b0110, 4'b0110, 1'b1, 1'b0, 1'b0);
        chk("b2b_idle_hold", {2'b00, out_valid, cout, sum}, 8'b0001_0000);

        // Reset discards a pending operation
        drive_wait(4'b0111, 4'b0111, 1'b1, 1'b1, 1'b1);
        chk("reset_discard", {sum, cout, group_p, group_g, out_valid}, 8'b0000_0000);

        // Exhaustive sweep, one vector per cycle
        for (int i = 0; i < 512; i++) begin
            drive(4'(i % 16), 4'((i / 16) % 16), 1'((i / 256) % 2), 1'b1, 1'b0);
        end

        // Randomized phase with random valid and occasional reset
        for (int i = 0; i < 2000; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 31) == 0));
        end

        drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
